// File: rtl/midi_voice_ctrl.sv
// MIDI note/CC parser driving a small polyphonic voice allocator.
// Byte capture -> parser -> voice update, so voice outputs trail the completing byte by two edges.
module midi_voice_ctrl #(
    parameter int NUM_VOICES   = 4,
    parameter int MIDI_CHANNEL = 0
) (
    input  logic                    clk_i,
    input  logic                    nrst_i,
    input  logic                    dataReady_i,
    input  logic [7:0]              midiData_i,
    output logic [NUM_VOICES-1:0]   voiceGate_o,
    output logic [7*NUM_VOICES-1:0] voiceNote_o,
    output logic [7*NUM_VOICES-1:0] voiceVel_o,
    output logic                    noteEvent_o
);
    localparam int PW = $clog2(NUM_VOICES);

    typedef enum logic [2:0] {IDLE, KEY, VEL, CC_NUM, CC_VAL, SKIP} state_t;
    typedef enum logic [1:0] {EV_ON, EV_OFF, EV_ALLOFF} evKind_t;

    // Edge detect resets to 1 so a level already high at reset release is not a byte.
    logic       drPrev, byteVld;
    logic [7:0] byteQ;

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            drPrev  <= 1'b1;
            byteVld <= 1'b0;
            byteQ   <= '0;
        end else begin
            drPrev  <= dataReady_i;
            byteVld <= dataReady_i & ~drPrev;
            if (dataReady_i & ~drPrev) byteQ <= midiData_i;
        end
    end

    state_t     state;
    logic       rsValid, rsCC, rsOn;
    logic [6:0] dataA;
    logic       evVld;
    evKind_t    evKind;
    logic [6:0] evKey, evVel;

    logic isChan, isNoteStat, isCCStat;
    assign isChan     = (byteQ[3:0] == 4'(MIDI_CHANNEL));
    assign isNoteStat = isChan && (byteQ[7:4] == 4'h8 || byteQ[7:4] == 4'h9);
    assign isCCStat   = isChan && (byteQ[7:4] == 4'hB);

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            state   <= IDLE;
            rsValid <= 1'b0;
            rsCC    <= 1'b0;
            rsOn    <= 1'b0;
            dataA   <= '0;
            evVld   <= 1'b0;
            evKind  <= EV_ON;
            evKey   <= '0;
            evVel   <= '0;
        end else begin
            evVld <= 1'b0;
            if (byteVld && byteQ < 8'hF8) begin
                if (byteQ[7]) begin
                    if (isNoteStat) begin
                        rsValid <= 1'b1;
                        rsCC    <= 1'b0;
                        rsOn    <= byteQ[4];
                        state   <= KEY;
                    end else if (isCCStat) begin
                        rsValid <= 1'b1;
                        rsCC    <= 1'b1;
                        state   <= CC_NUM;
                    end else begin
                        rsValid <= 1'b0;
                        state   <= SKIP;
                    end
                end else begin
                    case (state)
                        IDLE, SKIP: if (rsValid) begin
                            dataA <= byteQ[6:0];
                            state <= rsCC ? CC_VAL : VEL;
                        end
                        KEY: begin
                            dataA <= byteQ[6:0];
                            state <= VEL;
                        end
                        VEL: begin
                            evVld  <= 1'b1;
                            evKind <= (rsOn && byteQ[6:0] != 7'd0) ? EV_ON : EV_OFF;
                            evKey  <= dataA;
                            evVel  <= byteQ[6:0];
                            state  <= IDLE;
                        end
                        CC_NUM: begin
                            dataA <= byteQ[6:0];
                            state <= CC_VAL;
                        end
                        CC_VAL: begin
                            if (dataA == 7'd123 || dataA == 7'd120) begin
                                evVld  <= 1'b1;
                                evKind <= EV_ALLOFF;
                            end
                            state <= IDLE;
                        end
                        default: state <= IDLE;
                    endcase
                end
            end
        end
    end

    logic [NUM_VOICES-1:0]       gateQ;
    logic [NUM_VOICES-1:0][6:0]  noteQ, velQ;
    logic [PW-1:0]               stealPtr;

    logic [NUM_VOICES-1:0] matchVec;
    logic [PW-1:0]         hitIdx, freeIdx, onIdx;
    logic                  steal;

    // Descending scan so the lowest matching / free index wins.
    always_comb begin
        matchVec = '0;
        hitIdx   = '0;
        freeIdx  = '0;
        for (int v = NUM_VOICES - 1; v >= 0; v--) begin
            matchVec[v] = gateQ[v] && (noteQ[v] == evKey);
            if (matchVec[v]) hitIdx = PW'(v);
            if (!gateQ[v]) freeIdx = PW'(v);
        end
        steal = ~|matchVec & &gateQ;
        onIdx = (|matchVec) ? hitIdx : (!(&gateQ) ? freeIdx : stealPtr);
    end

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            gateQ       <= '0;
            noteQ       <= '0;
            velQ        <= '0;
            stealPtr    <= '0;
            noteEvent_o <= 1'b0;
        end else begin
            noteEvent_o <= 1'b0;
            if (evVld) begin
                case (evKind)
                    EV_ON: begin
                        gateQ[onIdx] <= 1'b1;
                        noteQ[onIdx] <= evKey;
                        velQ[onIdx]  <= evVel;
                        noteEvent_o  <= 1'b1;
                        if (steal)
                            stealPtr <= (stealPtr == PW'(NUM_VOICES - 1)) ? '0 : stealPtr + PW'(1);
                    end
                    EV_OFF: begin
                        gateQ       <= gateQ & ~matchVec;
                        noteEvent_o <= |matchVec;
                    end
                    default: begin
                        gateQ       <= '0;
                        noteEvent_o <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign voiceGate_o = gateQ;
    assign voiceNote_o = noteQ;
    assign voiceVel_o  = velQ;

endmodule

// File: tb/tb_midi_voice_ctrl.sv
// Bench for midi_voice_ctrl: message-level model compared every cycle, plus literal spot checks.
module tb_midi_voice_ctrl;
    localparam int N = 4;

    logic           clk, nrst, dataReady;
    logic [7:0]     midiData;
    logic [N-1:0]   voiceGate;
    logic [7*N-1:0] voiceNote, voiceVel;
    logic           noteEvent;

    midi_voice_ctrl #(.NUM_VOICES(N), .MIDI_CHANNEL(0)) dut (
        .clk_i(clk), .nrst_i(nrst), .dataReady_i(dataReady), .midiData_i(midiData),
        .voiceGate_o(voiceGate), .voiceNote_o(voiceNote), .voiceVel_o(voiceVel),
        .noteEvent_o(noteEvent)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nAssert = 0;
    int nFail   = 0;
    int edgeCnt = 0;
    int pulseCnt = 0;

    // Model: voice table, running status, collected data bytes, pending events with due edge.
    typedef struct { int due; int kind; int k; int v; } ev_t;
    ev_t pq[$];
    int mGate[N], mNote[N], mVel[N];
    int mPtr, rs, cnt, d0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nAssert++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < N; i++) begin
            mGate[i] = 0; mNote[i] = 0; mVel[i] = 0;
        end
        mPtr = 0; rs = -1; cnt = 0; d0 = 0;
        pq.delete();
    endtask

    // kind: 0 note-on, 1 note-off, 2 all-notes-off
    task automatic modelApply(input int kind, input int k, input int v, output bit pulse);
        int idx;
        pulse = 0;
        if (kind == 2) begin
            for (int i = 0; i < N; i++) mGate[i] = 0;
            pulse = 1;
        end else if (kind == 0 && v != 0) begin
            idx = -1;
            for (int i = 0; i < N; i++) if (idx < 0 && mGate[i] == 1 && mNote[i] == k) idx = i;
            for (int i = 0; i < N; i++) if (idx < 0 && mGate[i] == 0) idx = i;
            if (idx < 0) begin
                idx = mPtr;
                mPtr = (mPtr + 1) % N;
            end
            mGate[idx] = 1; mNote[idx] = k; mVel[idx] = v;
            pulse = 1;
        end else begin
            for (int i = 0; i < N; i++)
                if (mGate[i] == 1 && mNote[i] == k) begin
                    mGate[i] = 0;
                    pulse = 1;
                end
        end
    endtask

    task automatic modelByte(input logic [7:0] b);
        ev_t e;
        if (b >= 8'hF8) return;
        if (b[7]) begin
            if (b[3:0] == 4'h0 && (b[7:4] == 4'h8 || b[7:4] == 4'h9 || b[7:4] == 4'hB)) rs = int'(b);
            else rs = -1;
            cnt = 0;
        end else if (rs >= 0) begin
            if (cnt == 0) begin
                d0 = int'(b);
                cnt = 1;
            end else begin
                cnt = 0;
                e.due = edgeCnt + 3;
                e.k = d0;
                e.v = int'(b);
                if (rs[7:4] == 4'hB) begin
                    if (d0 == 120 || d0 == 123) begin
                        e.kind = 2;
                        pq.push_back(e);
                    end
                end else begin
                    e.kind = (rs[7:4] == 4'h9) ? 0 : 1;
                    pq.push_back(e);
                end
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        edgeCnt = edgeCnt + 1;
    end

    // Per-cycle comparison against the model.
    initial forever begin
        ev_t e;
        bit p, evNow;
        logic [N-1:0]   eg;
        logic [7*N-1:0] en, ev;
        @(negedge clk);
        #1;
        evNow = 0;
        while (pq.size() > 0 && pq[0].due <= edgeCnt) begin
            e = pq.pop_front();
            modelApply(e.kind, e.k, e.v, p);
            if (p && e.due == edgeCnt) evNow = 1;
        end
        for (int i = 0; i < N; i++) begin
            eg[i] = mGate[i][0];
            en[7*i +: 7] = 7'(mNote[i]);
            ev[7*i +: 7] = 7'(mVel[i]);
        end
        if (noteEvent === 1'b1) pulseCnt++;
        check("cyc_gate", voiceGate, eg);
        check("cyc_note", voiceNote, en);
        check("cyc_vel", voiceVel, ev);
        check("cyc_event", noteEvent, evNow);
    end

    task automatic sendByte(input logic [7:0] b, input int hold = 1);
        @(negedge clk);
        midiData = b;
        dataReady = 1'b1;
        modelByte(b);
        repeat (hold) @(negedge clk);
        dataReady = 1'b0;
    endtask

    task automatic send3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        sendByte(a); sendByte(b); sendByte(c);
    endtask

    task automatic doReset();
        @(negedge clk);
        nrst = 1'b0;
        modelReset();
        repeat (2) @(negedge clk);
        nrst = 1'b1;
    endtask

    task automatic settle();
        repeat (5) @(negedge clk);
        #2;
    endtask

    int p0;

    initial begin
        nrst = 1'b0; dataReady = 1'b0; midiData = 8'h00;
        modelReset();
        repeat (3) @(negedge clk);
        #2;
        check("rst_gate", voiceGate, 0);
        check("rst_note", voiceNote, 0);
        check("rst_vel", voiceVel, 0);
        check("rst_event", noteEvent, 0);
        @(negedge clk);
        nrst = 1'b1;

        // Basic note-on
        p0 = pulseCnt;
        send3(8'h90, 8'h3C, 8'h64);
        settle();
        check("on_gate", voiceGate, 4'b0001);
        check("on_note0", voiceNote[6:0], 7'h3C);
        check("on_vel0", voiceVel[6:0], 7'h64);
        check("on_pulses", pulseCnt - p0, 1);

        // Running status, velocity-0 note-off
        doReset();
        send3(8'h90, 8'h3C, 8'h40);
        sendByte(8'h3E); sendByte(8'h40);
        sendByte(8'h3C); sendByte(8'h00);
        settle();
        check("rs_gate", voiceGate, 4'b0010);
        check("rs_note0", voiceNote[6:0], 7'h3C);
        check("rs_note1", voiceNote[13:7], 7'h3E);

        // Stealing, retrigger, note-off
        doReset();
        send3(8'h90, 8'h30, 8'h50);
        for (int k = 8'h31; k <= 8'h34; k++) begin
            sendByte(8'(k)); sendByte(8'h50);
        end
        settle();
        check("steal_notes", voiceNote, {7'h33, 7'h32, 7'h31, 7'h34});
        sendByte(8'h35); sendByte(8'h51);
        settle();
        check("steal_ptr1", voiceNote[13:7], 7'h35);
        sendByte(8'h33); sendByte(8'h22);
        send3(8'h80, 8'h32, 8'h10);
        sendByte(8'h77); sendByte(8'h00);
        settle();
        check("off_gate", voiceGate, 4'b1011);
        check("retrig_vel3", voiceVel[27:21], 7'h22);
        send3(8'h90, 8'h36, 8'h11);
        settle();
        check("free_note2", voiceNote[20:14], 7'h36);

        // Realtime mid-message, foreign channel
        doReset();
        p0 = pulseCnt;
        sendByte(8'h90); sendByte(8'h40); sendByte(8'hF8); sendByte(8'h41);
        send3(8'h91, 8'h40, 8'h40);
        sendByte(8'h45); sendByte(8'h46);
        settle();
        check("rt_gate", voiceGate, 4'b0001);
        check("rt_note0", voiceNote[6:0], 7'h40);
        check("rt_vel0", voiceVel[6:0], 7'h41);
        check("rt_pulses", pulseCnt - p0, 1);

        // All notes off via CC 123
        send3(8'h90, 8'h50, 8'h10);
        sendByte(8'h51); sendByte(8'h10);
        settle();
        p0 = pulseCnt;
        send3(8'hB0, 8'h7B, 8'h00);
        settle();
        check("cc123_gate", voiceGate, 0);
        check("cc123_pulses", pulseCnt - p0, 1);

        // Other CC ignored, CC 120 via running status
        p0 = pulseCnt;
        send3(8'h90, 8'h20, 8'h30);
        sendByte(8'h21); sendByte(8'h30);
        send3(8'hB0, 8'h07, 8'h10);
        settle();
        check("cc7_gate", voiceGate, 4'b0011);
        sendByte(8'h78); sendByte(8'h00);
        settle();
        check("cc120_gate", voiceGate, 0);
        check("cc120_pulses", pulseCnt - p0, 3);

        // Status mid-message abandons the note
        p0 = pulseCnt;
        sendByte(8'h90); sendByte(8'h50);
        send3(8'hB0, 8'h7B, 8'h00);
        settle();
        check("abandon_gate", voiceGate, 0);
        check("abandon_pulses", pulseCnt - p0, 1);

        // SysEx clears running status
        send3(8'h90, 8'h22, 8'h33);
        sendByte(8'hF0); sendByte(8'h22); sendByte(8'h00);
        sendByte(8'hF7); sendByte(8'h22); sendByte(8'h00);
        settle();
        check("sysex_gate", voiceGate, 4'b0001);

        // Long-high dataReady counts once
        doReset();
        p0 = pulseCnt;
        sendByte(8'h90, 1); sendByte(8'h3C, 4); sendByte(8'h64, 3);
        settle();
        check("long_gate", voiceGate, 4'b0001);
        check("long_pulses", pulseCnt - p0, 1);

        // Reset mid-message
        doReset();
        p0 = pulseCnt;
        sendByte(8'h90); sendByte(8'h3C);
        doReset();
        sendByte(8'h64);
        settle();
        check("rstmid_gate", voiceGate, 0);
        check("rstmid_pulses", pulseCnt - p0, 0);

        // dataReady held high across reset release produces no byte
        p0 = pulseCnt;
        @(negedge clk);
        nrst = 1'b0;
        modelReset();
        midiData = 8'h90;
        dataReady = 1'b1;
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        repeat (2) @(negedge clk);
        dataReady = 1'b0;
        sendByte(8'h3C); sendByte(8'h64);
        settle();
        check("held_gate", voiceGate, 0);
        check("held_pulses", pulseCnt - p0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end
endmodule
